// File: rtl/image_downsample2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sift_img_pkg
// Purpose  : Shared types and helpers for the 2x image downsampler.
//            - ds_mode_t  : per-frame reduction mode (decimate / 2x2 average)
//            - ds_state_t : frame-activity state
//            - ds_addr_width() : output address width for a given input size
// Revision : 1.0 - initial release
// ============================================================================
package sift_img_pkg;

  typedef enum logic [0:0] {
    DS_DECIMATE = 1'b0,
    DS_AVERAGE  = 1'b1
  } ds_mode_t;

  typedef enum logic [0:0] {
    DS_IDLE   = 1'b0,
    DS_ACTIVE = 1'b1
  } ds_state_t;

  // Width needed to address a half-resolution image. Never returns zero so a
  // 2x2 input still yields a legal one-bit address bus.
  function automatic int ds_addr_width(input int in_width, input int in_height);
    int n;
    n = (in_width / 2) * (in_height / 2);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/image_downsample2_if.sv
`default_nettype none
// ============================================================================
// Module   : image_downsample2_if
// Purpose  : Pixel stream bundle for image_downsample2.
// Ports    : data_in/data_x_in/data_y_in/data_valid_in/mode_in - input stream
//            data_out/data_addr_out/data_valid_out             - output stream
//            frame_done_out/error_out/busy_out                 - status
//            master : stream source / sink side (drives the *_in signals)
//            slave  : downsampler side (drives the *_out signals)
// Revision : 1.0 - initial release
// ============================================================================
interface image_downsample2_if #(
  parameter int BIT_DEPTH   = 8,
  parameter int COORD_WIDTH = 8,
  parameter int ADDR_WIDTH  = 12
);
  logic [BIT_DEPTH-1:0]   data_in;
  logic [COORD_WIDTH-1:0] data_x_in;
  logic [COORD_WIDTH-1:0] data_y_in;
  logic                   data_valid_in;
  logic                   mode_in;
  logic [BIT_DEPTH-1:0]   data_out;
  logic [ADDR_WIDTH-1:0]  data_addr_out;
  logic                   data_valid_out;
  logic                   frame_done_out;
  logic                   error_out;
  logic                   busy_out;

  modport master (
    output data_in, data_x_in, data_y_in, data_valid_in, mode_in,
    input  data_out, data_addr_out, data_valid_out, frame_done_out,
           error_out, busy_out
  );

  modport slave (
    input  data_in, data_x_in, data_y_in, data_valid_in, mode_in,
    output data_out, data_addr_out, data_valid_out, frame_done_out,
           error_out, busy_out
  );
endinterface
`default_nettype wire

// File: rtl/image_downsample2_linebuf.sv
`default_nettype none
// ============================================================================
// Module   : ds_pair_linebuf
// Purpose  : Half-width line buffer holding horizontal pair sums of the
//            previous even row. One synchronous write port, one
//            combinational read port. Contents are not reset.
// Ports    : clk_i   - clock
//            we_i    - write enable
//            waddr_i - write entry index
//            wdata_i - pair sum to store
//            raddr_i - read entry index
//            rdata_o - stored pair sum (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module ds_pair_linebuf #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 9,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  wire logic             clk_i,
  input  wire logic             we_i,
  input  wire logic [AW-1:0]    waddr_i,
  input  wire logic [WIDTH-1:0] wdata_i,
  input  wire logic [AW-1:0]    raddr_i,
  output logic      [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/image_downsample2.sv
`default_nettype none
// ============================================================================
// Module   : image_downsample2
// Purpose  : Reduces a raster-order pixel stream to half resolution, either by
//            keeping the top-left pixel of each 2x2 block or by rounding the
//            2x2 block average. Checks raster order (sticky error) and reports
//            frame activity.
// Config   : IMAGE_DOWNSAMPLE_AVG_EN - when defined, average mode and its line
//            buffer are built; otherwise mode_in is ignored (always decimate).
// Ports    : clk_in - clock
//            rst_in - synchronous active-high reset
//            bus    - image_downsample2_if.slave (pixel in, pixel out, status)
// Revision : 1.0 - initial release
// ============================================================================
module image_downsample2
  import sift_img_pkg::*;
#(
  parameter int BIT_DEPTH   = 8,
  parameter int IN_WIDTH    = 128,
  parameter int IN_HEIGHT   = 128,
  parameter int COORD_WIDTH = 8,
  parameter int ADDR_WIDTH  = ds_addr_width(IN_WIDTH, IN_HEIGHT)
) (
  input wire logic           clk_in,
  input wire logic           rst_in,
  image_downsample2_if.slave bus
);

  localparam logic [COORD_WIDTH-1:0] c_x_last = COORD_WIDTH'(IN_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] c_y_last = COORD_WIDTH'(IN_HEIGHT - 1);
  localparam logic [COORD_WIDTH-1:0] c_x_pen  = COORD_WIDTH'(IN_WIDTH - 2);
  localparam logic [COORD_WIDTH-1:0] c_y_pen  = COORD_WIDTH'(IN_HEIGHT - 2);

  ds_state_t              state_q, state_d;
  ds_mode_t               mode_q;
  logic [COORD_WIDTH-1:0] ex_q, ex_d;
  logic [COORD_WIDTH-1:0] ey_q, ey_d;
  logic                   error_q;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;
  logic [BIT_DEPTH-1:0]   data_q, data_d;
  logic [ADDR_WIDTH-1:0]  addr_q;

  logic                   w_pix_origin;
  logic                   w_exp_origin;
  logic                   w_match;
  logic                   w_restart;
  logic                   w_accept;
  logic                   w_start;
  logic                   w_x_last;
  logic                   w_y_last;
  logic                   w_frame_end;
  logic                   w_err;
  ds_mode_t               w_mode_sel;
  ds_mode_t               w_mode_cur;
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic                   w_busy;

  // --------------------------------------------------------------------------
  // Raster-order check and acceptance
  // --------------------------------------------------------------------------
  assign w_pix_origin = (bus.data_x_in == '0) && (bus.data_y_in == '0);
  assign w_exp_origin = (ex_q == '0) && (ey_q == '0);
  assign w_match      = bus.data_valid_in && (bus.data_x_in == ex_q) &&
                        (bus.data_y_in == ey_q);
  // A (0,0) pixel out of turn is taken as the start of a fresh frame.
  assign w_restart    = bus.data_valid_in && w_pix_origin && !w_exp_origin;
  assign w_accept     = w_match || w_restart;
  assign w_start      = w_accept && w_pix_origin;
  assign w_err        = bus.data_valid_in && !w_match;
  assign w_x_last     = (bus.data_x_in == c_x_last);
  assign w_y_last     = (bus.data_y_in == c_y_last);
  assign w_frame_end  = w_accept && w_x_last && w_y_last;

`ifdef IMAGE_DOWNSAMPLE_AVG_EN
  assign w_mode_sel = ds_mode_t'(bus.mode_in);
`else
  logic w_unused_mode;
  assign w_mode_sel    = DS_DECIMATE;
  assign w_unused_mode = bus.mode_in;
`endif

  // The frame's first pixel already obeys the mode being latched with it.
  assign w_mode_cur = w_start ? w_mode_sel : mode_q;

  // Accepted pixels always sit at (x, y) == the driven coordinates, so the
  // next expected position is derived from them (this also covers restarts).
  always_comb begin
    ex_d = ex_q;
    ey_d = ey_q;
    if (w_accept) begin
      if (w_x_last) begin
        ex_d = '0;
        ey_d = w_y_last ? '0 : bus.data_y_in + COORD_WIDTH'(1);
      end else begin
        ex_d = bus.data_x_in + COORD_WIDTH'(1);
        ey_d = bus.data_y_in;
      end
    end
  end

  assign w_addr = ADDR_WIDTH'(int'(bus.data_y_in >> 1) * (IN_WIDTH / 2) +
                              int'(bus.data_x_in >> 1));

  // --------------------------------------------------------------------------
  // Average path: pair sums of even rows are parked in the line buffer and
  // combined with the odd-row pair sum to form the 2x2 total.
  // --------------------------------------------------------------------------
`ifdef IMAGE_DOWNSAMPLE_AVG_EN
  localparam int c_lb_aw = (IN_WIDTH / 2 > 1) ? $clog2(IN_WIDTH / 2) : 1;

  logic [BIT_DEPTH-1:0] hold_q;
  logic [BIT_DEPTH:0]   w_pair;
  logic [BIT_DEPTH:0]   w_lb_rd;
  logic [BIT_DEPTH+1:0] w_total;
  logic [BIT_DEPTH-1:0] w_avg;
  logic                 w_lb_we;
  logic [c_lb_aw-1:0]   w_lb_idx;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hold_q <= '0;
    end else if (w_accept && !bus.data_x_in[0]) begin
      hold_q <= bus.data_in;
    end
  end

  assign w_pair   = {1'b0, hold_q} + {1'b0, bus.data_in};
  assign w_total  = {1'b0, w_pair} + {1'b0, w_lb_rd};
  // Max total is 4*(2^B-1); adding 2 stays below 2^(B+2), so no carry out.
  assign w_avg    = BIT_DEPTH'((w_total + (BIT_DEPTH + 2)'(2)) >> 2);
  assign w_lb_idx = c_lb_aw'(bus.data_x_in >> 1);
  assign w_lb_we  = w_accept && bus.data_x_in[0] && !bus.data_y_in[0] &&
                    (w_mode_cur == DS_AVERAGE);

  ds_pair_linebuf #(
    .DEPTH (IN_WIDTH / 2),
    .WIDTH (BIT_DEPTH + 1),
    .AW    (c_lb_aw)
  ) u_linebuf (
    .clk_i   (clk_in),
    .we_i    (w_lb_we),
    .waddr_i (w_lb_idx),
    .wdata_i (w_pair),
    .raddr_i (w_lb_idx),
    .rdata_o (w_lb_rd)
  );
`endif

  // --------------------------------------------------------------------------
  // Output selection
  // --------------------------------------------------------------------------
  always_comb begin
    valid_d = 1'b0;
    done_d  = 1'b0;
    data_d  = bus.data_in;
    if (w_mode_cur == DS_DECIMATE) begin
      valid_d = w_accept && !bus.data_x_in[0] && !bus.data_y_in[0];
      done_d  = valid_d && (bus.data_x_in == c_x_pen) &&
                (bus.data_y_in == c_y_pen);
    end
`ifdef IMAGE_DOWNSAMPLE_AVG_EN
    else begin
      valid_d = w_accept && bus.data_x_in[0] && bus.data_y_in[0];
      done_d  = w_frame_end;
      data_d  = w_avg;
    end
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mode_q  <= DS_DECIMATE;
      ex_q    <= '0;
      ey_q    <= '0;
      error_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      if (w_start) begin
        mode_q <= w_mode_sel;
      end
      ex_q    <= ex_d;
      ey_q    <= ey_d;
      error_q <= error_q | w_err;
      valid_q <= valid_d;
      done_q  <= done_d;
      if (valid_d) begin
        data_q <= data_d;
        addr_q <= w_addr;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame activity FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= DS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (w_start) begin
      state_d = DS_ACTIVE;
    end else if ((state_q == DS_ACTIVE) && w_frame_end) begin
      state_d = DS_IDLE;
    end
  end

  // In average mode the FSM is already idle while the last output is shown;
  // the frame-done pulse keeps busy asserted through that cycle.
  always_comb begin
    w_busy = 1'b0;
    if ((state_q == DS_ACTIVE) || done_q) begin
      w_busy = 1'b1;
    end
  end

  assign bus.data_out       = data_q;
  assign bus.data_addr_out  = addr_q;
  assign bus.data_valid_out = valid_q;
  assign bus.frame_done_out = done_q;
  assign bus.error_out      = error_q;
  assign bus.busy_out       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_image_downsample2.sv
`default_nettype none
// ============================================================================
// Module   : tb_image_downsample2
// Purpose  : Self-checking bench for image_downsample2 on a 4x4 frame. A frame
//            image model computes expected outputs from whole 2x2 blocks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_image_downsample2;

  localparam int BD = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int CW = 8;
  localparam int AW = 2;

`ifdef IMAGE_DOWNSAMPLE_AVG_EN
  localparam bit AVG_BUILD = 1'b1;
`else
  localparam bit AVG_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  image_downsample2_if #(.BIT_DEPTH(BD), .COORD_WIDTH(CW), .ADDR_WIDTH(AW)) bus ();

  image_downsample2 #(
    .BIT_DEPTH   (BD),
    .IN_WIDTH    (W),
    .IN_HEIGHT   (H),
    .COORD_WIDTH (CW),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  // Reference model state
  int ex, ey;
  bit m_err, m_active, m_mode;
  bit e_valid, e_done, e_busy;
  int e_data, e_addr;
  int img [H][W];
  int fv  [H][W];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("busy_out", 32'(bus.busy_out), 32'(e_busy));
    check("error_out", 32'(bus.error_out), 32'(m_err));
    check("data_valid_out", 32'(bus.data_valid_out), 32'(e_valid));
    check("frame_done_out", 32'(bus.frame_done_out), 32'(e_done));
    if (e_valid) begin
      check("data_out", 32'(bus.data_out), 32'(e_data));
      check("data_addr_out", 32'(bus.data_addr_out), 32'(e_addr));
    end
  endtask

  task automatic model_pixel(input bit v, input int x, input int y, input int d, input bit m);
    bit match, origin, restart;
    e_valid = 1'b0;
    e_done  = 1'b0;
    if (v) begin
      match   = (x == ex) && (y == ey);
      origin  = (x == 0) && (y == 0);
      restart = origin && !((ex == 0) && (ey == 0));
      if (!match) m_err = 1'b1;
      if (match || restart) begin
        if (origin) begin
          m_mode   = AVG_BUILD && m;
          m_active = 1'b1;
        end
        img[y][x] = d;
        if (!m_mode) begin
          if ((x % 2 == 0) && (y % 2 == 0)) begin
            e_valid = 1'b1;
            e_data  = d;
            e_addr  = (y / 2) * (W / 2) + x / 2;
            e_done  = (x == W - 2) && (y == H - 2);
          end
        end else if ((x % 2 == 1) && (y % 2 == 1)) begin
          e_valid = 1'b1;
          e_data  = (img[y-1][x-1] + img[y-1][x] + img[y][x-1] + img[y][x] + 2) / 4;
          e_addr  = (y / 2) * (W / 2) + x / 2;
          e_done  = (x == W - 1) && (y == H - 1);
        end
        if ((x == W - 1) && (y == H - 1)) m_active = 1'b0;
        if (x == W - 1) begin
          ex = 0;
          ey = (y == H - 1) ? 0 : y + 1;
        end else begin
          ex = x + 1;
          ey = y;
        end
      end
    end
    e_busy = m_active || e_done;
  endtask

  task automatic step(input bit v, input int x, input int y, input int d, input bit m);
    @(negedge clk);
    bus.data_valid_in = v;
    bus.data_x_in     = CW'(x);
    bus.data_y_in     = CW'(y);
    bus.data_in       = BD'(d);
    bus.mode_in       = m;
    model_pixel(v, x, y, d, m);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_step();
    step(1'b0, $urandom_range(0, 255), $urandom_range(0, 255),
         $urandom_range(0, 255), 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.data_valid_in = 1'b0;
    ex = 0; ey = 0;
    m_err = 1'b0; m_active = 1'b0; m_mode = 1'b0;
    e_valid = 1'b0; e_done = 1'b0; e_busy = 1'b0;
    @(posedge clk);
    #1;
    check_outputs();
    check("data_out_rst", 32'(bus.data_out), 32'd0);
    check("data_addr_out_rst", 32'(bus.data_addr_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Sends a whole frame from fv; mode only matters on pixel (0,0), so other
  // pixels carry a random mode_in that must be ignored.
  task automatic send_frame(input bit m, input int gmin, input int gmax);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        step(1'b1, x, y, fv[y][x],
             ((x == 0) && (y == 0)) ? m : 1'($urandom_range(0, 1)));
        repeat ($urandom_range(gmax, gmin)) idle_step();
      end
    end
    idle_step();
  endtask

  task automatic fill_ramp();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) fv[y][x] = 4 * y + x;
  endtask

  task automatic fill_const(input int v);
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) fv[y][x] = v;
  endtask

  task automatic fill_rand();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) fv[y][x] = $urandom_range(0, 255);
  endtask

  initial begin
    bus.data_valid_in = 1'b0;
    bus.data_x_in     = '0;
    bus.data_y_in     = '0;
    bus.data_in       = '0;
    bus.mode_in       = 1'b0;
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 0;

    // Reset state
    do_reset();

    // Decimate ramp frame: 0,2,8,10 at 0..3
    fill_ramp();
    send_frame(1'b0, 0, 0);

    // Average ramp frame: 3,5,11,13
    send_frame(1'b1, 0, 0);

    // Average saturation: all 255
    fill_const(255);
    send_frame(1'b1, 0, 0);

    // Rounding: block 1,2,2,2 -> 2
    fill_rand();
    fv[0][0] = 1; fv[0][1] = 2; fv[1][0] = 2; fv[1][1] = 2;
    send_frame(1'b1, 0, 1);

    // Raster error: skipped column is dropped, frame then completes
    do_reset();
    fill_ramp();
    step(1'b1, 0, 0, fv[0][0], 1'b0);
    step(1'b1, 1, 0, fv[0][1], 1'b0);
    step(1'b1, 3, 0, fv[0][3], 1'b0);
    step(1'b1, 2, 0, fv[0][2], 1'b0);
    step(1'b1, 3, 0, fv[0][3], 1'b0);
    step(1'b1, 5, 1, 77, 1'b0);
    for (int i = W; i < W * H; i++) step(1'b1, i % W, i / W, fv[i / W][i % W], 1'b0);
    idle_step();

    // Restart into average mode, then finish with 3-cycle gaps
    do_reset();
    fill_rand();
    step(1'b1, 0, 0, 9, 1'b0);
    step(1'b1, 1, 0, 9, 1'b0);
    send_frame(1'b1, 3, 3);

    // Reset mid-frame, then a clean frame
    do_reset();
    fill_rand();
    for (int i = 0; i < 6; i++) step(1'b1, i % W, i / W, fv[i / W][i % W], 1'b1);
    do_reset();
    fill_rand();
    send_frame(1'b1, 0, 0);

    // Random frames, modes and gaps
    repeat (6) begin
      fill_rand();
      send_frame(1'($urandom_range(0, 1)), 0, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/image_downsample2.md
Name: image_downsample2

Overview:
- Parametrised successor to the existing 2x pixel decimator.
- Takes a raster-order pixel stream with (x,y) coordinates and produces a half-resolution image stream with linear output addresses.
- Selectable per frame between decimation (keep the top-left pixel of each 2x2 block) and 2x2 box averaging, which uses a half-width line buffer of pair sums.
- Also checks raster order and reports frame activity.
- Sits between the image source BRAM reader and the octave pyramid BRAM writer.

Parameters:
- BIT_DEPTH, 8, pixel width.
- IN_WIDTH, 128, input row length; even, at least 2.
- IN_HEIGHT, 128, input rows; even, at least 2.
- COORD_WIDTH, 8, width of x/y coordinate inputs.
- ADDR_WIDTH, $clog2((IN_WIDTH/2)*(IN_HEIGHT/2)), output address width.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous active-high reset.
- data_in  input  BIT_DEPTH  pixel value.
- data_x_in  input  COORD_WIDTH  pixel column.
- data_y_in  input  COORD_WIDTH  pixel row.
- data_valid_in  input  1  pixel strobe.
- mode_in  input  1  0 = decimate, 1 = average; sampled only when pixel (0,0) is accepted.
- data_out  output  BIT_DEPTH  output pixel.
- data_addr_out  output  ADDR_WIDTH  (y>>1)*(IN_WIDTH/2) + (x>>1).
- data_valid_out  output  1  output strobe, one cycle.
- frame_done_out  output  1  one-cycle pulse coincident with the last output pixel of a frame.
- error_out  output  1  sticky raster-order error.
- busy_out  output  1  frame in progress.

Behaviour:
- Clock and reset: one clock, clk_in. rst_in is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; expected position (0,0); mode register decimate. Reset mid-frame discards partial sums; line buffer contents are don't-care after reset.
- Expected-position counter (ex, ey): advances on every accepted pixel; x wraps at IN_WIDTH-1 and increments y. After (IN_WIDTH-1, IN_HEIGHT-1) it returns to (0,0).
- Acceptance rules (evaluated only when data_valid_in=1):
  - Coordinates equal (ex, ey): pixel accepted.
  - Coordinates (0,0) but expected is not (0,0): frame restart. Set error_out, then accept the pixel as a new frame start. Partial sums are discarded.
  - Any other mismatch, including x >= IN_WIDTH or y >= IN_HEIGHT: set error_out, drop the pixel, leave counters unchanged.
- Accepting (0,0) latches mode_in. Mode is fixed for the rest of the frame.
- State machine:
  - IDLE -> ACTIVE on accepting (0,0).
  - ACTIVE -> IDLE in the cycle after the final output is registered, i.e. on accepting the last pixel (IN_WIDTH-1, IN_HEIGHT-1).
  - busy_out is 1 in ACTIVE, and stays 1 during the cycle in which the last data_valid_out/frame_done_out is high. It is 0 in IDLE.
- Decimate mode:
  - An accepted pixel with x even and y even produces an output one cycle later (registered).
  - data_out = data_in; address as defined on the port.
  - Last output of the frame is at (IN_WIDTH-2, IN_HEIGHT-2). frame_done_out pulses with it; the FSM still waits for the final input pixel before returning to IDLE.
- Average mode:
  - Even-x pixel: held in a BIT_DEPTH register.
  - Odd-x pixel: pair sum (BIT_DEPTH+1 bits) = held + data_in.
  - Even row: pair sum written to line buffer entry x>>1.
  - Odd row: total (BIT_DEPTH+2 bits) = pair sum + buffer[x>>1].
  - Output one cycle after the odd-x/odd-y pixel: data_out = (total + 2) >> 2, round half up, never exceeds 2^BIT_DEPTH - 1.
  - Address uses that pixel's x>>1, y>>1. frame_done_out pulses with output (IN_WIDTH/2-1, IN_HEIGHT/2-1).
- Gaps: data_valid_in may drop for any number of cycles mid-frame. State is held and no output is generated.
- Error: error_out clears only on rst_in.

Optional Feature:
- Macro: IMAGE_DOWNSAMPLE_AVG_EN.
- Defined: average mode and line buffer are present, as described above.
- Undefined: mode_in is ignored and the mode is always decimate. No line buffer or pair-sum logic is instantiated. All other behaviour is unchanged.

Decomposition:
- Package sift_img_pkg holds:
  - typedef enum ds_mode_t {DS_DECIMATE, DS_AVERAGE};
  - typedef enum ds_state_t {DS_IDLE, DS_ACTIVE};
  - localparam function for the output address width.
- Sub-module ds_pair_linebuf: IN_WIDTH/2 entries x (BIT_DEPTH+1) bits, one synchronous write port and one combinational read port. Instantiated only under IMAGE_DOWNSAMPLE_AVG_EN.

Test Plan:
- Bench parameters: IN_WIDTH=4, IN_HEIGHT=4.
- Decimate, frame pixel value = 4*y + x -> outputs 0, 2, 8, 10 at addresses 0, 1, 2, 3. Each arrives 1 cycle after its pixel. frame_done_out is with 10; busy_out falls after pixel (3,3).
- Average, same frame -> outputs 3 (0+1+4+5=10, (10+2)>>2=3), 5, 11, 13 at addresses 0-3. error_out stays 0.
- Average, all pixels 255 -> all outputs 255, no overflow. Pixels 1,2,2,2 in a block (sum 7) -> output 2.
- Raster error: send (0,0), (1,0), then (3,0) -> error_out=1, pixel dropped. Then (2,0), (3,0) are accepted and the frame completes normally.
- Restart and gaps: send (0,0), (1,0), (0,0) with mode_in=1 -> error_out=1, new frame in average mode. Then complete that frame with 3-cycle valid gaps -> correct averages and addresses.
- Reset mid-frame: after 6 pixels, assert rst_in for 1 cycle -> all outputs 0, busy_out=0. A new full frame then produces the correct outputs.
